// File: rtl/shader_array_sequencer.sv
// rtl/shader_array_sequencer.sv - frame sequencer for the ROWS x COLS pixel_shader array
//
// Purpose:
//   Runs one frame through the shader array. The camera is latched at
//   frame_start. Voxels are pulled one at a time from an upstream valid/ready
//   stream. Each voxel is broadcast with a one-cycle shader_valid pulse, and
//   the sequencer waits for the array-wide rasterizing_done before pulling the
//   next one. After the last voxel it waits for shading_done. It then walks
//   row/col across the shared pixel bus and streams the pixels to the
//   framebuffer writer.
//
// Ports:
//   clock, reset                      clock; asynchronous active-low reset
//   frame_start                       one-cycle frame request (honoured in IDLE only)
//   cam_in_pos_*, cam_in_look_*       camera inputs, sampled at frame_start
//   in_valid/in_ready/in_x/y/z/id/in_last   upstream voxel stream
//   shader_valid, voxel_*, cam_*      broadcast to every shader
//   all_raster_done, all_shade_done   AND-reduced shader status
//   row, col, pixel                   shared pixel bus select and data
//   out_valid/out_ready/out_pixel/out_row/out_col   pixel stream out
//   busy, frame_done, timeout_err     frame status
module shader_array_sequencer #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = 8,
  parameter int PALETTE_BITS = 8,
  parameter int PIXEL_BITS   = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [31:0]             cam_in_pos_x,
  input  logic [31:0]             cam_in_pos_y,
  input  logic [31:0]             cam_in_pos_z,
  input  logic [31:0]             cam_in_look_x,
  input  logic [31:0]             cam_in_look_y,
  input  logic [31:0]             cam_in_look_z,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COORD_BITS-1:0]   in_x,
  input  logic [COORD_BITS-1:0]   in_y,
  input  logic [COORD_BITS-1:0]   in_z,
  input  logic [PALETTE_BITS-1:0] in_id,
  input  logic                    in_last,
  output logic                    shader_valid,
  output logic [COORD_BITS-1:0]   voxel_x,
  output logic [COORD_BITS-1:0]   voxel_y,
  output logic [COORD_BITS-1:0]   voxel_z,
  output logic [PALETTE_BITS-1:0] voxel_id,
  output logic [31:0]             cam_pos_x,
  output logic [31:0]             cam_pos_y,
  output logic [31:0]             cam_pos_z,
  output logic [31:0]             cam_look_x,
  output logic [31:0]             cam_look_y,
  output logic [31:0]             cam_look_z,
  input  logic                    all_raster_done,
  input  logic                    all_shade_done,
  output logic [ROW_BITS-1:0]     row,
  output logic [COL_BITS-1:0]     col,
  input  logic [PIXEL_BITS-1:0]   pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIXEL_BITS-1:0]   out_pixel,
  output logic [ROW_BITS-1:0]     out_row,
  output logic [COL_BITS-1:0]     out_col,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT_RASTER, WAIT_SHADE, READOUT, DONE
  } state_t;

  localparam int WAIT_BITS = $clog2(TIMEOUT + 1);

  state_t               state, state_nxt;
  logic [WAIT_BITS-1:0] wait_cnt;
  logic                 last_flag;

  logic frame_go, accept, in_wait, wait_expired;
  logic raster_hit, raster_go, shade_go, timeout_hit;
  logic col_last, row_last, px_accept;

  assign frame_go     = (state == IDLE) && frame_start;
  assign accept       = (state == LOAD) && in_valid && in_ready;
  assign in_wait      = (state == WAIT_RASTER) || (state == WAIT_SHADE);
  assign wait_expired = in_wait && (wait_cnt == WAIT_BITS'(TIMEOUT - 1));
  // Shaders still show the previous voxel's done in the first wait cycle,
  // so raster done is only trusted once the counter has moved off zero.
  assign raster_hit   = (state == WAIT_RASTER) && (wait_cnt != '0) && all_raster_done;
  assign raster_go    = raster_hit || ((state == WAIT_RASTER) && wait_expired);
  assign shade_go     = (state == WAIT_SHADE) && (all_shade_done || wait_expired);
  // A genuine done arriving in the expiry cycle is not a timeout.
  assign timeout_hit  = wait_expired && !raster_hit
                        && !((state == WAIT_SHADE) && all_shade_done);
  assign col_last     = (col == COL_BITS'(COLS - 1));
  assign row_last     = (row == ROW_BITS'(ROWS - 1));
  assign px_accept    = (state == READOUT) && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_pixel = '0;
    out_row   = '0;
    out_col   = '0;
    case (state)
      IDLE:        if (frame_go) state_nxt = LOAD;
      LOAD:        if (accept) state_nxt = ISSUE;
      ISSUE:       state_nxt = WAIT_RASTER;
      WAIT_RASTER: if (raster_go) state_nxt = last_flag ? WAIT_SHADE : LOAD;
      WAIT_SHADE:  if (shade_go) state_nxt = READOUT;
      READOUT: begin
        out_valid = 1'b1;
        out_pixel = pixel;
        out_row   = row;
        out_col   = col;
        if (px_accept && col_last && row_last) state_nxt = DONE;
      end
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready     <= 1'b0;
      shader_valid <= 1'b0;
      voxel_x      <= '0;
      voxel_y      <= '0;
      voxel_z      <= '0;
      voxel_id     <= '0;
      last_flag    <= 1'b0;
      cam_pos_x    <= '0;
      cam_pos_y    <= '0;
      cam_pos_z    <= '0;
      cam_look_x   <= '0;
      cam_look_y   <= '0;
      cam_look_z   <= '0;
      row          <= '0;
      col          <= '0;
      wait_cnt     <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // in_ready mirrors "next state is LOAD", so it is high for the whole
      // LOAD visit and drops the cycle after the single accepted voxel.
      in_ready     <= (state_nxt == LOAD);
      shader_valid <= accept;
      frame_done   <= (state_nxt == DONE);

      if (state_nxt != state) wait_cnt <= '0;
      else if (in_wait)       wait_cnt <= wait_cnt + WAIT_BITS'(1);

      if (frame_go) begin
        cam_pos_x   <= cam_in_pos_x;
        cam_pos_y   <= cam_in_pos_y;
        cam_pos_z   <= cam_in_pos_z;
        cam_look_x  <= cam_in_look_x;
        cam_look_y  <= cam_in_look_y;
        cam_look_z  <= cam_in_look_z;
        busy        <= 1'b1;
        timeout_err <= 1'b0;
      end
      if (timeout_hit) timeout_err <= 1'b1;

      if (accept) begin
        voxel_x   <= in_x;
        voxel_y   <= in_y;
        voxel_z   <= in_z;
        voxel_id  <= in_id;
        last_flag <= in_last;
      end

      if (shade_go) begin
        row <= '0;
        col <= '0;
      end else if (px_accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_BITS'(1);
        end else begin
          col <= col + COL_BITS'(1);
        end
      end

      if (state_nxt == DONE) busy <= 1'b0;
    end
  end

endmodule
